vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Upstream stage of the snake renderer: generates 640x480@60 Hz VGA timing from the 100 MHz board clock.
- Provides the pixel clock-enable, the sync pulses, the active-video flag, the pixel coordinates, and line/frame strobes.
- Everything runs on a single clock domain using a clock-enable, with no derived clocks. The renderer consumes x/y/de and gates its RGB output with de.

Parameters:
- DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz); legal range is 2 or more.
- H_ACT, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_ACT, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  synchronous active-low reset.
- pix_ce  out  1  one-clk pulse every DIV clks; marks a pixel step.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- de  out  1  active-video flag.
- x  out  10  pixel column 0..H_ACT-1 while de=1; 0 otherwise.
- y  out  10  pixel row 0..V_ACT-1 while de=1; 0 otherwise.
- line_start  out  1  one-clk pulse when the h=0 pixel is presented.
- frame_start  out  1  one-clk pulse when the h=0, v=0 pixel is presented.

Behaviour:
- Reset: a synchronous, active-low reset is sampled on posedge clk. Reset values are div_cnt=0, h_cnt=0, v_cnt=0, pix_ce=0, vga_hs=1, vga_vs=1, de=0, x=0, y=0, line_start=0, frame_start=0.
- Reset mid-frame: reset returns all state to these values on the next edge. Timing restarts from h=0, v=0; no partial-frame recovery.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - The pix_ce register is set to 1 on the edge where div_cnt==DIV-1, so pix_ce is high for exactly 1 clk in every DIV.
  - The first pix_ce after reset release is high during the 4th clk period (DIV=4).
- Counters advance only in a clk cycle where pix_ce=1:
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL = 800), then wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1 (V_TOTAL = 525), then wraps to 0.
  - Both wrap on the same edge at (799, 524).
- Line layout (h_cnt): active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Frame layout (v_cnt): active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Output registers load on the same pix_ce edge that advances the counters. They decode the pre-increment (h_cnt, v_cnt), so the outputs lag the counters by one pixel and all outputs are mutually aligned.
  - de = (h_cnt < H_ACT) && (v_cnt < V_ACT).
  - x = de ? h_cnt : 0; y = de ? v_cnt : 0.
  - vga_hs = 0 when h_cnt is in [656, 751].
  - vga_vs = 0 when v_cnt is in [490, 491], for the whole of those lines.
  - line_start = (h_cnt==0) && pix_ce; frame_start = line_start && (v_cnt==0).
  - line_start and frame_start are cleared on the next clk edge, so each is exactly 1 clk wide.
- Between pix_ce pulses all outputs hold their values.
- Width rules:
  - Counters are 10 bits; totals up to 1023 are representable.
  - Compare with >= / < against parameter-derived constants only; no multipliers.
- Guarantees to downstream:
  - x, y, and de change only on pix_ce edges.
  - x never exceeds 639 and y never exceeds 479.

Decomposition:
- Shared package vga_pkg holds the timing constants and derived values:
  - H_TOTAL and V_TOTAL.
  - H_SYNC_START = H_ACT + H_FRONT and H_SYNC_END = H_SYNC_START + H_SYNC - 1.
  - V_SYNC_START and V_SYNC_END, derived the same way.
  - The renderer shares the same package.
- One sub-module, clk_en_div: a parameterised divider producing pix_ce. The snake step clock and the debounce tick reuse it with large DIV.
- The h/v counters and output decode stay in the top module.

Test Plan:
- Reset release: check DIV spacing and first-pixel outputs.
  - pix_ce pulses at clk cycles 4, 8, 12 with a period of exactly 4 clks.
  - The first pix_ce edge gives de=1, x=0, y=0, line_start=1, frame_start=1.
- Horizontal timing over one full line:
  - Count pix_ce pulses: de=1 for 640, and vga_hs=0 for exactly 96, with its first low pixel at index 656.
  - line_start pulses once every 800 pix_ce.
- Vertical timing over one full frame:
  - vga_vs=0 for exactly 2×800 pix_ce, starting at line 490.
  - frame_start period is 420000 pix_ce (1,680,000 clk).
  - de is never 1 on lines 480..524.
- Coordinate bounds over two frames: assert x ≤ 639 and y ≤ 479 whenever de=1, and x=y=0 whenever de=0.
- Wrap: at the (799, 524) pixel, the next pix_ce gives x=0, y=0, de=1, frame_start=1, and there is no extra line.
- Mid-frame reset:
  - Assert rst_n=0 for 3 clks at line 200, pixel 300.
  - Outputs must equal the reset values on the edge following the first low sample.
  - After release the sequence repeats the reset-release scenario exactly.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: VGA 640x480@60 Hz timing constants shared by the timing
// generator and the snake renderer.
// Holds the porch/sync/active widths, the derived totals, the sync window
// bounds, and a small window-decode helper.
package vga_pkg;

  // Base timing, in pixels (horizontal) and lines (vertical).
  localparam int VGA_DIV     = 4;
  localparam int VGA_H_ACT   = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_V_ACT   = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;

  // Derived values. The sync window bounds are inclusive.
  localparam int VGA_H_TOTAL      = VGA_H_ACT + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL      = VGA_V_ACT + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_H_SYNC_START = VGA_H_ACT + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_ACT + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  // Returns 1 when lo <= val < hi_excl. Only compares are used, no arithmetic.
  function automatic logic in_span(input logic [9:0] val,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi_excl);
    return (val >= lo) && (val < hi_excl);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: clock-enable divider. It produces a one-clk pulse every DIV clks.
// The pulse is not a derived clock, so it can also drive slow ticks such as
// the snake step and the debounce sample.
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset
//   ce_o     registered enable, high for 1 clk in every DIV (DIV >= 2)
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic ce_o
);

  localparam int            W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         ce_q;

  // Next divider count: wrap after DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = {W{1'b0}};
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Divider state and the enable register. The enable is set on the edge
  // where the count sits at DIV-1.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= {W{1'b0}};
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= (cnt_q == LAST);
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator. It runs on one clock domain
// and uses a pixel clock-enable.
// Ports:
//   clk, rst_n             system clock, synchronous active-low reset
//   pix_ce                 pixel-step enable (one clk every DIV)
//   vga_hs, vga_vs         active-low sync pulses
//   de, x, y               active-video flag and coordinates (x,y = 0 when de = 0)
//   line_start             1-clk pulse with the h=0 pixel
//   frame_start            1-clk pulse with the h=0, v=0 pixel
// The registered outputs decode the pre-increment counters on each pix_ce
// edge. They therefore trail the counters by one pixel, and all outputs stay
// aligned with each other.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int DIV     = VGA_DIV,
  parameter int H_ACT   = VGA_H_ACT,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int V_ACT   = VGA_V_ACT,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BACK  = VGA_V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_ce,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST    = 10'(H_ACT + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACT + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_ACT_C   = 10'(H_ACT);
  localparam logic [9:0] V_ACT_C   = 10'(V_ACT);
  localparam logic [9:0] HS_LO     = 10'(H_ACT + H_FRONT);
  localparam logic [9:0] HS_HI_X   = 10'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO     = 10'(V_ACT + V_FRONT);
  localparam logic [9:0] VS_HI_X   = 10'(V_ACT + V_FRONT + V_SYNC);

  logic       ce_s;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       de_s, hs_s, vs_s;
  logic       hs_q, vs_q, de_q, ls_q, fs_q;
  logic [9:0] x_q, y_q;

  clk_en_div #(.DIV(DIV)) u_div (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .ce_o    (ce_s)
  );

  // Raster counters: h wraps after H_LAST and carries into v.
  // Both counters wrap together at the last pixel of the frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce_s) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q;
    end
  end

  // Decode of the current counter position.
  always_comb begin
    de_s = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_s = ~in_span(h_cnt_q, HS_LO, HS_HI_X);
    vs_s = ~in_span(v_cnt_q, VS_LO, VS_HI_X);
  end

  // Counter state and output registers. The outputs load only on pixel steps.
  // The strobes clear on the next clk so that each one lasts exactly 1 clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (ce_s) begin
        hs_q <= hs_s;
        vs_q <= vs_s;
        de_q <= de_s;
        x_q  <= de_s ? h_cnt_q : 10'd0;
        y_q  <= de_s ? v_cnt_q : 10'd0;
        ls_q <= (h_cnt_q == 10'd0);
        fs_q <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      end else begin
        ls_q <= 1'b0;
        fs_q <= 1'b0;
      end
    end
  end

  assign pix_ce      = ce_s;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
